// File: rtl/mem_bank_ctrl.sv
// Round-robin two-port arbiter and setup/strobe/hold sequencer for a latch-based word bank.
// Define MEM_BANK_CTRL_READBACK_EN to add a post-write VERIFY state driving err.
module mem_bank_ctrl #(
   parameter int WORDS  = 4,
   parameter int ADDR_W = 2,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              op0,
   input  logic              op1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              valid,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              busy,
   output logic              bank_rw,
   output logic [WORDS-1:0]  bank_sel,
   output logic [DATA_W-1:0] bank_wdata,
   input  logic [DATA_W-1:0] bank_rdata_n
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_VERIFY,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t state;
   logic   ptr;
   logic   win;
   logic   op_q;

   logic              win_c;
   logic              op_c;
   logic [ADDR_W-1:0] addr_c;
   logic [DATA_W-1:0] wdata_c;

   // Out-of-range addresses decode to an all-zero select.
   function automatic logic [WORDS-1:0] decode(input logic [ADDR_W-1:0] a);
      logic [WORDS-1:0] r;
      r = '0;
      for (int i = 0; i < WORDS; i++) begin
         r[i] = (int'(a) == i);
      end
      return r;
   endfunction

   // ptr names the requester that wins a tie.
   always_comb begin
      win_c   = (req0 && req1) ? ptr : req1;
      op_c    = win_c ? op1    : op0;
      addr_c  = win_c ? addr1  : addr0;
      wdata_c = win_c ? wdata1 : wdata0;
   end

`ifndef MEM_BANK_CTRL_READBACK_EN
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         ptr        <= 1'b0;
         win        <= 1'b0;
         op_q       <= 1'b0;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         valid      <= 1'b0;
         rdata      <= '0;
         busy       <= 1'b0;
         bank_rw    <= 1'b0;
         bank_sel   <= '0;
         bank_wdata <= '0;
`ifdef MEM_BANK_CTRL_READBACK_EN
         err        <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req0 || req1) begin
                  win        <= win_c;
                  op_q       <= op_c;
                  gnt0       <= ~win_c;
                  gnt1       <= win_c;
                  busy       <= 1'b1;
                  bank_sel   <= decode(addr_c);
                  bank_wdata <= wdata_c;
                  state      <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (op_q) begin
                  bank_rw <= 1'b1;
                  state   <= S_STROBE;
               end else begin
                  state   <= S_SAMPLE;
               end
            end
            S_STROBE: begin
               bank_rw <= 1'b0;
               state   <= S_HOLD;
            end
            S_HOLD: begin
`ifdef MEM_BANK_CTRL_READBACK_EN
               state    <= S_VERIFY;
`else
               valid    <= 1'b1;
               bank_sel <= '0;
               state    <= S_DONE;
`endif
            end
`ifdef MEM_BANK_CTRL_READBACK_EN
            S_VERIFY: begin
               // Select is still held, so the word's output is stable here.
               err      <= (|bank_sel) && ((~bank_rdata_n) != bank_wdata);
               valid    <= 1'b1;
               bank_sel <= '0;
               state    <= S_DONE;
            end
`endif
            S_SAMPLE: begin
               rdata    <= ~bank_rdata_n;
               valid    <= 1'b1;
               bank_sel <= '0;
               state    <= S_DONE;
            end
            S_DONE: begin
               valid <= 1'b0;
               gnt0  <= 1'b0;
               gnt1  <= 1'b0;
               busy  <= 1'b0;
               ptr   <= ~win;
`ifdef MEM_BANK_CTRL_READBACK_EN
               err   <= 1'b0;
`endif
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Directed bench for mem_bank_ctrl with a behavioural latch-bank model.
module tb_mem_bank_ctrl;

`ifdef MEM_BANK_CTRL_READBACK_EN
   localparam int WLAT = 5;
   localparam logic RB = 1'b1;
`else
   localparam int WLAT = 4;
   localparam logic RB = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       req0, req1, op0, op1;
   logic [1:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, valid, err, busy, bank_rw;
   logic [7:0] rdata, bank_wdata, bank_rdata_n;
   logic [3:0] bank_sel;

   logic       r3_req, r3_op;
   logic [1:0] r3_addr;
   logic       g3_0, g3_1, v3, e3, b3, rw3;
   logic [7:0] rd3, wd3, rn3;
   logic [2:0] sel3;
   logic       z1 = 1'b0;
   logic [1:0] za = 2'd0;
   logic [7:0] zd = 8'd0;

   logic [7:0] mem [4];
   logic       stuck;

   int n_chk = 0;
   int n_pass = 0;
   logic [7:0] rd;
   logic       er;

   always #5 clk = ~clk;

   mem_bank_ctrl #(.WORDS(4), .ADDR_W(2), .DATA_W(8)) u_dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .valid(valid), .rdata(rdata), .err(err),
      .busy(busy), .bank_rw(bank_rw), .bank_sel(bank_sel),
      .bank_wdata(bank_wdata), .bank_rdata_n(bank_rdata_n)
   );

   mem_bank_ctrl #(.WORDS(3), .ADDR_W(2), .DATA_W(8)) u_dut3 (
      .clk(clk), .reset(reset),
      .req0(r3_req), .req1(z1), .op0(r3_op), .op1(z1),
      .addr0(r3_addr), .addr1(za), .wdata0(zd), .wdata1(zd),
      .gnt0(g3_0), .gnt1(g3_1), .valid(v3), .rdata(rd3), .err(e3),
      .busy(b3), .bank_rw(rw3), .bank_sel(sel3),
      .bank_wdata(wd3), .bank_rdata_n(rn3)
   );

   // Bank model: selected word drives its inverted contents, others all-ones.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (reset) mem[i] <= 8'h00;
         else if (bank_sel[i] && bank_rw) mem[i] <= bank_wdata;
      end
   end

   always_comb begin
      bank_rdata_n = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         if (bank_sel[i]) bank_rdata_n = bank_rdata_n & ~(mem[i] & (stuck ? 8'hFE : 8'hFF));
      end
   end

   assign rn3 = (|sel3) ? 8'h96 : 8'hFF;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic run(input logic who, input logic op, input logic [1:0] a,
                      input logic [7:0] d, input int lat, input string tag,
                      output logic [7:0] rdo, output logic ero);
      int cyc;
      if (who) begin req1 = 1'b1; op1 = op; addr1 = a; wdata1 = d; end
      else     begin req0 = 1'b1; op0 = op; addr0 = a; wdata0 = d; end
      cyc = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         cyc++;
         if (valid) break;
      end
      chk({tag, "_lat"}, cyc, lat);
      chk({tag, "_gnt"}, {gnt1, gnt0}, who ? 2'b10 : 2'b01);
      rdo = rdata;
      ero = err;
      req0 = 1'b0;
      req1 = 1'b0;
      step();
   endtask

   initial begin
      reset = 1'b1; stuck = 1'b0;
      req0 = 0; req1 = 0; op0 = 0; op1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      r3_req = 0; r3_op = 0; r3_addr = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", {gnt1, gnt0}, 2'b00);
      chk("rst_flags", {valid, err, busy, bank_rw}, 4'b0000);
      chk("rst_sel", bank_sel, 4'b0000);
      chk("rst_data", {bank_wdata, rdata}, 16'h0000);
      reset = 1'b0;
      step();

      // Write 0xA5 to addr 2, cycle by cycle.
      req0 = 1; op0 = 1; addr0 = 2'd2; wdata0 = 8'hA5;
      step();
      chk("w_c1_sel", bank_sel, 4'b0100);
      chk("w_c1_rw", bank_rw, 1'b0);
      chk("w_c1_gnt", {gnt1, gnt0, busy}, 3'b011);
      chk("w_c1_wd", bank_wdata, 8'hA5);
      op0 = 0; addr0 = 2'd0; wdata0 = 8'hFF;
      step();
      chk("w_c2_rw", bank_rw, 1'b1);
      chk("w_c2_sel", bank_sel, 4'b0100);
      step();
      chk("w_c3_rw", bank_rw, 1'b0);
      chk("w_c3_sel", bank_sel, 4'b0100);
      chk("w_c3_wd", bank_wdata, 8'hA5);
      chk("w_c3_vld", valid, 1'b0);
      if (RB) begin
         step();
         chk("w_c4_verify", {valid, bank_rw, bank_sel}, 6'b000100);
      end
      step();
      chk("w_done_vld", valid, 1'b1);
      chk("w_done_gnt", {gnt1, gnt0}, 2'b01);
      chk("w_done_sel", bank_sel, 4'b0000);
      chk("w_done_err", err, 1'b0);
      req0 = 0;
      step();
      chk("w_idle", {busy, valid, gnt1, gnt0}, 4'b0000);

      run(1'b0, 1'b0, 2'd2, 8'h00, 3, "rd_a5", rd, er);
      chk("rd_a5_data", rd, 8'hA5);
      run(1'b1, 1'b1, 2'd1, 8'h3C, WLAT, "wr_3c", rd, er);
      chk("rdata_hold", rd, 8'hA5);
      run(1'b1, 1'b0, 2'd1, 8'h00, 3, "rd_3c", rd, er);
      chk("rd_3c_data", rd, 8'h3C);

      // Both requesters held: grants alternate with one IDLE cycle between.
      req0 = 1; op0 = 0; addr0 = 2'd2;
      req1 = 1; op1 = 0; addr1 = 2'd1;
      for (int k = 1; k <= 16; k++) begin
         int ph;
         int tx;
         step();
         ph = (k - 1) % 4;
         tx = (k - 1) / 4;
         chk("rr_gnt0", gnt0, (ph < 3) && (tx % 2 == 0));
         chk("rr_gnt1", gnt1, (ph < 3) && (tx % 2 == 1));
         if (ph == 2) chk("rr_rdata", {valid, rdata}, (tx % 2 == 0) ? 9'h1A5 : 9'h13C);
      end
      req0 = 0; req1 = 0;
      step();

      // Reset landing in STROBE.
      req0 = 1; op0 = 1; addr0 = 2'd3; wdata0 = 8'h77;
      step();
      step();
      chk("rs_strobe", bank_rw, 1'b1);
      reset = 1; req0 = 0;
      step();
      chk("rs_rw_sel", {bank_rw, bank_sel}, 5'b00000);
      chk("rs_busy", {busy, valid, gnt0}, 3'b000);
      reset = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rs_novalid", {valid, busy}, 2'b00);
      end

      // WORDS=3 instance: in-range then out-of-range read.
      r3_req = 1; r3_op = 0; r3_addr = 2'd1;
      step();
      chk("w3_sel1", sel3, 3'b010);
      step();
      step();
      chk("w3_rd1", {v3, rd3}, 9'h169);
      r3_req = 0;
      step();
      r3_req = 1; r3_addr = 2'd3;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("w3_oor_sel", sel3, 3'b000);
      end
      chk("w3_oor_rd", {v3, rd3}, 9'h100);
      r3_req = 0;
      step();

      // Bit 0 stuck low in the bank.
      stuck = 1'b1;
      run(1'b0, 1'b1, 2'd0, 8'h01, WLAT, "rb_01", rd, er);
      chk("rb_01_err", er, RB);
      run(1'b0, 1'b1, 2'd0, 8'h02, WLAT, "rb_02", rd, er);
      chk("rb_02_err", er, 1'b0);
      stuck = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
